// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop writer.
// Optional feature: CROP_WRITER_TLAST_EN adds a last-pixel flag to the output payload.
package crop_pkg;

    localparam int unsigned PIX_W = 8;

    // Frame-crop control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    // Output beat payload; tlast only exists when the feature is built in
    typedef struct packed {
`ifdef CROP_WRITER_TLAST_EN
        logic             last;
`endif
        logic [PIX_W-1:0] data;
    } pix_t;

    // Counter/origin width for a dimension of n entries (at least 1 bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXIS output register with ready pass-back.
// Ports:
//   clk, srst                    clock and synchronous active-high reset
//   push_valid, push_pix         beat offered by the producer
//   push_ready_c                 register can take a beat this cycle
//   tvalid, tpix, tready         AXIS master side
module axis_out_reg
    import crop_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic push_valid,
    input  pix_t push_pix,
    output logic push_ready_c,
    output logic tvalid,
    output pix_t tpix,
    input  logic tready
);

    logic valid_q;
    pix_t pix_q;

    // Space is available when empty or when the held beat leaves this cycle
    assign push_ready_c = !valid_q || tready;

    // Payload only changes when the register can advance, so it holds while stalled
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
        end else if (push_ready_c) begin
            valid_q <= push_valid;
            if (push_valid) begin
                pix_q <= push_pix;
            end
        end
    end

    assign tvalid = valid_q;
    assign tpix   = pix_q;

endmodule

// File: rtl/crop_writer.sv
// Crops an OUT_ROWS x OUT_COLS window out of one raster camera frame and
// streams it on an AXIS master, under an ap_start/ap_ready/ap_done handshake.
// Optional feature: CROP_WRITER_TLAST_EN adds m_axis_tlast on the last window pixel.
// Ports:
//   clk, srst                       clock and synchronous active-high reset
//   ap_start, ap_ready, ap_done     frame-level control handshake
//   crop_row, crop_col              window origin, sampled when ap_start is accepted
//   s_axis_tvalid/tready/tdata/tuser  camera input stream (tuser marks pixel (0,0))
//   m_axis_tvalid/tready/tdata(/tlast) cropped output stream
module crop_writer
    import crop_pkg::*;
#(
    parameter int unsigned IN_ROWS  = 480,
    parameter int unsigned IN_COLS  = 640,
    parameter int unsigned OUT_ROWS = 10,
    parameter int unsigned OUT_COLS = 10
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    input  logic [cnt_w(IN_ROWS)-1:0]   crop_row,
    input  logic [cnt_w(IN_COLS)-1:0]   crop_col,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [PIX_W-1:0]            s_axis_tdata,
    input  logic                        s_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PIX_W-1:0]            m_axis_tdata
`ifdef CROP_WRITER_TLAST_EN
    ,
    output logic                        m_axis_tlast
`endif
);

    localparam int unsigned RW = cnt_w(IN_ROWS);
    localparam int unsigned CW = cnt_w(IN_COLS);

    localparam logic [RW-1:0] ROW_MAX    = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] COL_MAX    = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IN_COLS - 1);
    localparam logic [RW:0]   OUT_ROWS_X = (RW+1)'(OUT_ROWS);
    localparam logic [CW:0]   OUT_COLS_X = (CW+1)'(OUT_COLS);

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d, row0_q, row0_d, row_e;
    logic [CW-1:0] col_q, col_d, col0_q, col0_d, col_e;
    logic [RW:0]   row_off;
    logic [CW:0]   col_off;
    logic          in_win;
    logic          frame_end;
    logic          beat_ready;
    logic          take_beat;
    logic          push_valid;
    logic          push_ready_c;
    logic          out_valid;
    pix_t          push_pix;
    pix_t          out_pix;

    // Position of the beat on the input: a tuser beat is always pixel (0,0)
    always_comb begin
        row_e     = s_axis_tuser ? '0 : row_q;
        col_e     = s_axis_tuser ? '0 : col_q;
        // One extra bit: a position left of/above the origin wraps to a huge offset
        row_off   = (RW+1)'(row_e) - (RW+1)'(row0_q);
        col_off   = (CW+1)'(col_e) - (CW+1)'(col0_q);
        in_win    = (row_off < OUT_ROWS_X) && (col_off < OUT_COLS_X);
        frame_end = (row_e == ROW_LAST) && (col_e == COL_LAST);
    end

    // Next state, counters, origin latch and input handshake
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row0_d     = row0_q;
        col0_d     = col0_q;
        beat_ready = 1'b0;
        take_beat  = 1'b0;
        push_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    row0_d  = (crop_row > ROW_MAX) ? ROW_MAX : crop_row;
                    col0_d  = (crop_col > COL_MAX) ? COL_MAX : crop_col;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                // Pre-SOF beats are drained freely; the SOF beat may need output space
                beat_ready = (s_axis_tuser && in_win) ? push_ready_c : 1'b1;
                take_beat  = s_axis_tvalid && s_axis_tuser && beat_ready;
            end
            STREAM: begin
                // Out-of-window pixels never wait on the sink
                beat_ready = in_win ? push_ready_c : 1'b1;
                take_beat  = s_axis_tvalid && beat_ready;
            end
            DRAIN: begin
                if (!out_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_beat) begin
            push_valid = in_win;
            if (frame_end) begin
                state_d = DRAIN;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = STREAM;
                if (col_e == COL_LAST) begin
                    col_d = '0;
                    row_d = row_e + RW'(1);
                end else begin
                    col_d = col_e + CW'(1);
                    row_d = row_e;
                end
            end
        end
    end

    // Output payload for the beat being pushed
    always_comb begin
        push_pix      = '0;
        push_pix.data = s_axis_tdata;
`ifdef CROP_WRITER_TLAST_EN
        push_pix.last = (row_e == row0_q + RW'(OUT_ROWS - 1)) &&
                        (col_e == col0_q + CW'(OUT_COLS - 1));
`endif
    end

    // State, counters and latched origin
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            row0_q  <= '0;
            col0_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            row0_q  <= row0_d;
            col0_q  <= col0_d;
        end
    end

    axis_out_reg u_out (
        .clk          (clk),
        .srst         (srst),
        .push_valid   (push_valid),
        .push_pix     (push_pix),
        .push_ready_c (push_ready_c),
        .tvalid       (out_valid),
        .tpix         (out_pix),
        .tready       (m_axis_tready)
    );

    // Control outputs are pure decodes of flops
    assign ap_ready      = (state_q == IDLE);
    assign ap_done       = (state_q == DRAIN) && !out_valid;
    assign s_axis_tready = beat_ready;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_pix.data;
`ifdef CROP_WRITER_TLAST_EN
    assign m_axis_tlast  = out_pix.last;
`endif

endmodule

// File: tb/tb_crop_writer.sv
// Scoreboard bench for crop_writer on an 8x8 frame with a 4x4 window,
// pixel value = r*8+c.
module tb_crop_writer;

    localparam int unsigned IR = 8;
    localparam int unsigned IC = 8;
    localparam int unsigned OR = 4;
    localparam int unsigned OC = 4;

    logic       clk = 1'b0;
    logic       srst;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic [2:0] crop_row;
    logic [2:0] crop_col;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tuser;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
`ifdef CROP_WRITER_TLAST_EN
    logic       m_axis_tlast;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   out_cnt     = 0;
    int   done_cnt    = 0;
    int   frames_done = 0;
    bit   busy        = 1'b0;
    bit   abort       = 1'b0;
    bit   toggle      = 1'b0;
    bit   mon_stall   = 1'b0;
    logic [7:0] mon_data = 8'h00;

    always #5 clk = ~clk;

    crop_writer #(
        .IN_ROWS  (IR),
        .IN_COLS  (IC),
        .OUT_ROWS (OR),
        .OUT_COLS (OC)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .crop_row      (crop_row),
        .crop_col      (crop_col),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
`ifdef CROP_WRITER_TLAST_EN
        ,
        .m_axis_tlast  (m_axis_tlast)
`endif
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected window given as the four hand-computed row start values
    task automatic push_rows(input int b0, input int b1, input int b2, input int b3);
        int   b[4];
        exp_t e;
        b = '{b0, b1, b2, b3};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.data = 8'(b[r] + c);
                e.last = (r == 3) && (c == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    // Sink ready: always high, or toggling every cycle
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks AXIS hold rule
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (srst) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("hold_valid", int'(m_axis_tvalid), 1);
                    check("hold_data", int'(m_axis_tdata), int'(mon_data));
                end
                if (busy) check("ap_ready_busy", int'(ap_ready), 0);
                if (m_axis_tvalid && m_axis_tready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got tdata %0d, expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", int'(m_axis_tdata), int'(e.data));
`ifdef CROP_WRITER_TLAST_EN
                        check("tlast", int'(m_axis_tlast), int'(e.last));
`endif
                    end
                end
                mon_stall = m_axis_tvalid && !m_axis_tready;
                mon_data  = m_axis_tdata;
                if (ap_done) done_cnt++;
            end
        end
    end

    // Issue ap_start with an origin; hold keeps ap_start high afterwards
    task automatic start_crop(input int r, input int c, input bit hold);
        @(posedge clk);
        #1;
        ap_start = 1'b1;
        crop_row = 3'(r);
        crop_col = 3'(c);
        @(negedge clk);
        check("ready_idle", int'(ap_ready), 1);
        @(posedge clk);
        #1;
        ap_start = hold;
        crop_row = 3'd0;
        crop_col = 3'd0;
        out_cnt  = 0;
        busy     = 1'b1;
    endtask

    // Send junk pre-SOF beats then one full raster frame
    task automatic send_frame(input int junk, input bit gaps);
        int p;
        bit acc;
        for (int b = 0; b < junk + int'(IR * IC); b++) begin
            if (abort) break;
            p             = b - junk;
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = (p == 0);
            s_axis_tdata  = (p < 0) ? 8'hAA : 8'(p);
            acc           = 1'b0;
            for (int n = 0; n < 200 && !acc && !abort; n++) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
            end
            if (!acc && !abort) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: beat %0d not accepted, expected accept within 200 cycles", b);
                break;
            end
            if (gaps && (b % 5 == 4)) begin
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Wait for ap_done and check frame completion and the return to IDLE
    task automatic wait_done(input string nm, input int nbeats);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = ap_done;
        end
        busy = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done: ap_done not seen, expected within 2000 cycles", nm);
            ap_start = 1'b0;
            return;
        end
        check({nm, "_beats"}, out_cnt, nbeats);
        check({nm, "_pending"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        @(negedge clk);
        check({nm, "_done_pulse"}, int'(ap_done), 0);
        check({nm, "_ready_after"}, int'(ap_ready), 1);
        frames_done++;
        repeat (3) @(negedge clk);
        check({nm, "_done_count"}, done_cnt, frames_done);
        check({nm, "_stay_idle"}, int'(ap_ready), 1);
    endtask

    initial begin
        srst          = 1'b1;
        ap_start      = 1'b0;
        crop_row      = 3'd0;
        crop_col      = 3'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tuser  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ap_ready", int'(ap_ready), 1);
        check("rst_ap_done", int'(ap_done), 0);
        check("rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("rst_s_tready", int'(s_axis_tready), 0);
        check("rst_m_tdata", int'(m_axis_tdata), 0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // 1: origin (2,3), sink always ready
        push_rows(19, 27, 35, 43);
        start_crop(2, 3, 1'b0);
        send_frame(0, 1'b0);
        wait_done("s1", 16);

        // 2: origin (0,0), sink ready toggling, input gaps
        toggle = 1'b1;
        push_rows(0, 8, 16, 24);
        start_crop(0, 0, 1'b0);
        send_frame(0, 1'b1);
        wait_done("s2", 16);
        toggle = 1'b0;

        // 3: origin (7,7) clamps to (4,4)
        push_rows(36, 44, 52, 60);
        start_crop(7, 7, 1'b0);
        send_frame(0, 1'b0);
        wait_done("s3", 16);

        // 4: three junk beats before SOF
        push_rows(19, 27, 35, 43);
        start_crop(2, 3, 1'b0);
        send_frame(3, 1'b0);
        wait_done("s4", 16);

        // 5: reset mid-frame, then a full frame at origin (1,2)
        push_rows(10, 18, 26, 34);
        start_crop(1, 2, 1'b0);
        fork
            send_frame(0, 1'b0);
            begin
                for (int n = 0; n < 500 && out_cnt < 5; n++) @(negedge clk);
                if (out_cnt < 5) begin
                    checks++;
                    errors++;
                    $display("FAIL s5_beats_before_reset: got %0d, expected 5", out_cnt);
                end
                @(posedge clk);
                #1;
                srst  = 1'b1;
                abort = 1'b1;
                busy  = 1'b0;
                @(posedge clk);
                #1;
                srst = 1'b0;
                exp_q.delete();
            end
        join
        abort = 1'b0;
        @(negedge clk);
        check("s5_rst_ap_ready", int'(ap_ready), 1);
        check("s5_rst_m_tvalid", int'(m_axis_tvalid), 0);
        repeat (3) @(negedge clk);
        check("s5_no_done_on_reset", done_cnt, frames_done);
        push_rows(10, 18, 26, 34);
        start_crop(1, 2, 1'b0);
        send_frame(0, 1'b0);
        wait_done("s5", 16);

        // 6: ap_start held high through the frame; tlast only on 46
        push_rows(19, 27, 35, 43);
        start_crop(2, 3, 1'b1);
        send_frame(0, 1'b0);
        wait_done("s6", 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
